// File: rtl/stage_e_md.sv
// stage_e_md -- execute-stage multiply/divide unit with architectural HI/LO.
//
// Multi-cycle ops (mult, multu, div, divu and, with MD_MADD_EN defined,
// madd/maddu) latch their operands and count down a 4-bit cnt. When cnt
// reaches 1, HI/LO are written and done pulses in the following cycle.
// mthi/mtlo write HI/LO in a single cycle.
//
// Optional feature: define MD_MADD_EN to enable madd/maddu accumulate.
// With it undefined, op 6/7 is a no-op.
//
// Ports:
//   clk, reset    rising-edge clock, async active-high reset
//   start, op     request and opcode (0 mult .. 7 maddu)
//   a, b          operands (rs, rt)
//   flush         cancels any in-flight op; also blocks a same-edge start
//   busy          multi-cycle op in flight (cnt != 0)
//   md_stall      busy, or a multi-cycle op being requested this cycle
//   done          one-cycle pulse after HI/LO take a multi-cycle result
//   hi, lo        architectural HI/LO
module stage_e_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             md_stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [2:0] OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2,
                         OP_DIVU  = 3'd3, OP_MTHI  = 3'd4, OP_MTLO = 3'd5,
                         OP_MADD  = 3'd6, OP_MADDU = 3'd7;
  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept, is_mul, is_div, commit, wr;
  logic [2*WIDTH-1:0] res;

  // Request decode on the live inputs
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  assign accept   = (state == IDLE) && start && !flush;
  assign busy     = (cnt != 4'd0);
  assign md_stall = busy || (start && (is_mul || is_div));

  // Next state: cnt is the real state, state just names cnt==0 vs cnt!=0
  always_comb begin
    cnt_nx = cnt;
    commit = 1'b0;
    if (flush)
      cnt_nx = 4'd0;
    else if (state == RUN) begin
      commit = (cnt == 4'd1);
      cnt_nx = cnt - 4'd1;
    end else if (accept && is_mul)
      cnt_nx = MUL_N;
    else if (accept && is_div)
      cnt_nx = DIV_N;
    state_nx = (cnt_nx != 4'd0) ? RUN : IDLE;
  end

  // Datapath on latched operands. Bit 0 of the opcode clear means signed.
  logic             sgn, neg_a, neg_b, q_div;
  logic [WIDTH-1:0] ua, ub, q_u, r_u, q, r;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  always_comb begin
    sgn   = !op_q[0];
    q_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    ext_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;
    // Divide on magnitudes so truncation and remainder sign are explicit;
    // MIN / -1 falls out as quotient MIN, remainder 0.
    neg_a = sgn & a_q[WIDTH-1];
    neg_b = sgn & b_q[WIDTH-1];
    ua    = neg_a ? -a_q : a_q;
    ub    = neg_b ? -b_q : b_q;
    q_u   = (ub != '0) ? ua / ub : '0;
    r_u   = (ub != '0) ? ua % ub : '0;
    q     = (neg_a ^ neg_b) ? -q_u : q_u;
    r     = neg_a ? -r_u : r_u;
    if (q_div) begin
      res = {r, q};
      wr  = (ub != '0);
    end else begin
`ifdef MD_MADD_EN
      // Accumulate reads HI/LO as they stand at the commit edge
      res = ((op_q == OP_MADD) || (op_q == OP_MADDU)) ? ({hi, lo} + prod) : prod;
`else
      res = prod;
`endif
      wr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= commit;
      if (accept && (is_mul || is_div)) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (commit && wr)
        {hi, lo} <= res;
      else if (accept && op == OP_MTHI)
        hi <= a;
      else if (accept && op == OP_MTLO)
        lo <= a;
    end
  end
endmodule
